// File: rtl/if_stage_param.sv
// ----------------------------------------------------------------------------
// if_stage_param
// Instruction-fetch stage: PC register, next-PC select (PC+4 / branch),
// word-addressed instruction memory with a program-load write port, and the
// IF/ID pipeline register with stall, flush, valid tracking and a saturating
// count of valid instructions handed to ID.
//
// Optional feature macro: IF_ALIGN_CHECK_EN
//   defined   : misaligned redirects are rejected (PC+4 taken), misalign_if
//               pulses for one cycle.
//   undefined : branch target low two bits are forced to 00, misalign_if = 0.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   pc_write                   PC may update (0 = stall)
//   if_id_write                IF/ID may load (0 = hold)
//   flush                      squash IF/ID into a bubble
//   pcsrc, pc_branch           redirect select and target
//   imem_we/waddr/wdata        program-load write port
//   pc_if, instruction_if      contents of IF/ID
//   valid_if                   IF/ID holds a real instruction
//   misalign_if                rejected misaligned redirect (one-cycle pulse)
//   fetch_count                saturating count of valid IF/ID loads
// ----------------------------------------------------------------------------
module if_stage_param #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    IMEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [31:0]           NOP_INSTR   = 32'h0000_0013,
    parameter int                    COUNT_WIDTH = 16,
    localparam int                   IDX_W       = $clog2(IMEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pc_write,
    input  logic                   if_id_write,
    input  logic                   flush,
    input  logic                   pcsrc,
    input  logic [ADDR_WIDTH-1:0]  pc_branch,
    input  logic                   imem_we,
    input  logic [IDX_W-1:0]       imem_waddr,
    input  logic [31:0]            imem_wdata,
    output logic [ADDR_WIDTH-1:0]  pc_if,
    output logic [31:0]            instruction_if,
    output logic                   valid_if,
    output logic                   misalign_if,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    logic [31:0]            imem [IMEM_DEPTH];

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d, pc_plus4;
    logic [ADDR_WIDTH-1:0]  pc_if_q, pc_if_d;
    logic [31:0]            instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]            fetch_word;

    // Upper PC bits above the index alias onto the same words.
    assign fetch_word = imem[pc_q[IDX_W+1:2]];
    assign pc_plus4   = pc_q + ADDR_WIDTH'(4);

    // Program-load port; memory is never reset. Same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

`ifdef IF_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
`endif

    // Next-PC selection.
    always_comb begin
        pc_d = pc_q;
`ifdef IF_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        if (pc_write) begin
            if (pcsrc) begin
`ifdef IF_ALIGN_CHECK_EN
                if (pc_branch[1:0] != 2'b00) begin
                    pc_d       = pc_plus4;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = pc_branch;
                end
`else
                pc_d = pc_branch & ~ADDR_WIDTH'(3);
`endif
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // IF/ID register: flush beats load beats hold.
    always_comb begin
        pc_if_d = pc_if_q;
        instr_d = instr_q;
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            pc_if_d = pc_q;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (if_id_write) begin
            pc_if_d = pc_q;
            instr_d = fetch_word;
            valid_d = 1'b1;
            if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            pc_if_q <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            pc_if_q <= pc_if_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
    assign misalign_if = misalign_q;
`else
    assign misalign_if = 1'b0;
`endif

    assign pc_if          = pc_if_q;
    assign instruction_if = instr_q;
    assign valid_if       = valid_q;
    assign fetch_count    = count_q;

endmodule

// File: doc/if_stage_param.md
# if_stage_param

Parametrised instruction-fetch stage for the 5-stage pipeline: PC register, sequential/branch next-PC selection, word-addressed instruction memory with a program-load write port, and the IF/ID pipeline register with stall, flush and valid tracking. Sits between the hazard/branch logic (pcsrc, pc_branch, pc_write, if_id_write, flush) and the ID stage. It also keeps a saturating count of instructions delivered to ID.

## Interface
- ADDR_WIDTH, 32: PC and branch-target width, in bits; ≥ log2(IMEM_DEPTH)+2.
- IMEM_DEPTH, 1024: instruction memory size in 32-bit words; power of two.
- RESET_PC, 0: PC value after reset; word-aligned.
- NOP_INSTR, 32'h00000013: instruction presented to ID after reset or flush.
- COUNT_WIDTH, 16: width of fetch_count.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pc_write  in  1  1 = PC may update this cycle; 0 = PC holds (stall).
- if_id_write  in  1  1 = IF/ID register may load; 0 = holds.
- flush  in  1  squash IF/ID contents (branch taken in a later stage).
- pcsrc  in  1  1 = next PC is pc_branch; 0 = PC+4.
- pc_branch  in  ADDR_WIDTH  branch/jump target.
- imem_we  in  1  program-load write enable.
- imem_waddr  in  log2(IMEM_DEPTH)  word index written.
- imem_wdata  in  32  word written.
- pc_if  out  ADDR_WIDTH  PC of the instruction in IF/ID.
- instruction_if  out  32  instruction in IF/ID.
- valid_if  out  1  IF/ID holds a real instruction.
- misalign_if  out  1  rejected misaligned redirect (see Configuration).
- fetch_count  out  COUNT_WIDTH  number of valid IF/ID loads, saturating.

## Operation
- Internal pc register. The fetch word index is pc[log2(IMEM_DEPTH)+1:2]. Higher PC bits alias (modulo IMEM_DEPTH).
- Memory read is combinational: fetch_word = imem[index(pc)]. The memory is not reset.
- Memory write is synchronous: on a clk edge with imem_we=1, imem[imem_waddr] <= imem_wdata. A read of the same word in the same cycle returns the old data.
- Next PC, when pc_write=1: pcsrc ? pc_branch : pc+4. The sum wraps modulo 2^ADDR_WIDTH. When pc_write=0, pc holds; pcsrc is ignored.
- IF/ID register priority is flush > if_id_write > hold:
  - flush=1: instruction_if <= NOP_INSTR, pc_if <= pc, valid_if <= 0. This applies even when if_id_write=0.
  - if_id_write=1: instruction_if <= fetch_word, pc_if <= pc, valid_if <= 1.
  - Otherwise all three hold.
- fetch_count increments on each edge where IF/ID loads with valid (if_id_write=1, flush=0). It saturates at 2^COUNT_WIDTH-1.
- Reset (any time, including mid-stall or mid-flush):
  - pc = RESET_PC.
  - pc_if = 0, instruction_if = NOP_INSTR.
  - valid_if = 0, misalign_if = 0, fetch_count = 0.
  - Memory contents are unchanged.

## Timing
- All state updates on the rising edge of clk; reset acts immediately.
- Fetch latency: the instruction at pc appears on instruction_if one edge after the cycle in which pc is presented, with pc_if equal to that pc.
- A redirect (pcsrc=1, pc_write=1) at edge N gives pc=pc_branch after N. The target instruction is in IF/ID after N+1.
- Simultaneous flush and redirect in one cycle is legal. IF/ID becomes a bubble and PC takes pc_branch.
- Stalling: pc_write=0 with if_id_write=0 freezes the stage completely. pc_write=1 with if_id_write=0 is legal but drops the fetched word; the hazard unit must not do this.
- misalign_if is a registered one-cycle pulse.

## Configuration
- IF_ALIGN_CHECK_EN defined:
  - A redirect with pc_branch[1:0]≠0 (pcsrc=1, pc_write=1) is rejected. pc <= pc+4 instead.
  - misalign_if pulses 1 for the cycle after that edge.
- IF_ALIGN_CHECK_EN undefined:
  - pc_branch[1:0] is forced to 00 on every redirect.
  - misalign_if is constant 0.

## Test plan
- Reset, load imem[0..3]=A,B,C,D, release reset, all enables 1 → (pc_if, instruction_if) = (0,A),(4,B),(8,C),(12,D) on consecutive cycles, valid_if=1, fetch_count=4.
- pc_write=if_id_write=0 for 3 cycles while IF/ID holds (4,B) → outputs and fetch_count unchanged; resume → next is (8,C).
- pcsrc=1, pc_branch=0x20, flush=1 in one cycle → next cycle valid_if=0 and instruction_if=NOP_INSTR; following cycle pc_if=0x20 with imem[8].
- ADDR_WIDTH=12, pc=0xFFC → next pc=0x000. Also write and fetch the same word in one cycle → old word fetched, new word on the next fetch.
- pc_branch=0x22 redirect → with IF_ALIGN_CHECK_EN: pc=old+4 and misalign_if=1 for one cycle; without it: pc=0x20 and misalign_if=0.
- Assert reset mid-stall with fetch_count=5 → all outputs return to reset values immediately, and imem contents are preserved.
